// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - MMIO UART transmitter: byte FIFO feeding an 8N1 serialiser
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  output logic       tx_idle,
  output logic       tx_overflow,
  output logic       txd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic write_ok;
  logic pop;
  logic baud_tc;

  assign fifo_full  = (count_q == COUNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign write_ok   = tx_we && !fifo_full;
  assign baud_tc    = (baud_q == BAUD_LAST);

  // FIFO bookkeeping: a write into a full FIFO is dropped even if a pop frees a slot on the same edge
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = tx_we && fifo_full;
    if (write_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({write_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Serialiser next-state; txd is derived from the next state so the pin is a clean flop output
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    txd_d     = 1'b1;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        baud_d = baud_tc ? '0 : baud_q + BW'(1);
        if (baud_tc) begin
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = baud_tc ? '0 : baud_q + BW'(1);
        if (baud_tc) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        baud_d = baud_tc ? '0 : baud_q + BW'(1);
        if (baud_tc) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // State, pointers and line register; reset forces the line high at once and discards queued bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage captures tx_data at the accepting edge; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  assign txd         = txd_q;
  assign tx_overflow = overflow_q;
  assign tx_busy     = fifo_full;
  assign tx_idle     = (state_q == S_IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-timeline reference model
module tb_uart_tx;

  localparam int C  = 4;
  localparam int D  = 4;
  localparam int CB = 868;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data4, data8;
  logic       we4, we8;
  logic       busy4, idle4, ovf4, txd4;
  logic       busy8, idle8, ovf8, txd8;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut4 (
    .clk(clk), .rst_n(rst_n), .tx_data(data4), .tx_we(we4),
    .tx_busy(busy4), .tx_idle(idle4), .tx_overflow(ovf4), .txd(txd4)
  );

  uart_tx dut868 (
    .clk(clk), .rst_n(rst_n), .tx_data(data8), .tx_we(we8),
    .tx_busy(busy8), .tx_idle(idle8), .tx_overflow(ovf8), .txd(txd8)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queue of waiting bytes plus the timeline of the frame on the wire
  logic [7:0] q[$];
  int         n;
  bit         have_frame;
  int         fs;
  logic [7:0] fbyte;
  int         free_at;
  int         ovf_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    q.delete();
    have_frame = 1'b0;
    free_at    = 0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then check dut4
  task automatic step();
    bit   pop, acc, ovf, in_frame;
    int   k;
    logic exp_txd;
    @(posedge clk);
    pop = (q.size() > 0) && (n >= free_at);
    ovf = we4 && (q.size() == D);
    acc = we4 && (q.size() < D);
    if (pop) begin
      fbyte      = q.pop_front();
      fs         = n;
      have_frame = 1'b1;
      free_at    = n + 10 * C;
    end
    if (acc) q.push_back(data4);
    #1;
    in_frame = have_frame && (n < fs + 10 * C);
    if (!in_frame) exp_txd = 1'b1;
    else begin
      k = (n - fs) / C;
      if (k == 0)      exp_txd = 1'b0;
      else if (k <= 8) exp_txd = fbyte[k-1];
      else             exp_txd = 1'b1;
    end
    chk("txd", txd4, exp_txd);
    chk("tx_busy", busy4, q.size() == D);
    chk("tx_idle", idle4, !in_frame && q.size() == 0);
    chk("tx_overflow", ovf4, ovf);
    if (ovf4) ovf_seen++;
    n++;
  endtask

  task automatic wr4(input logic [7:0] d);
    we4   = 1'b1;
    data4 = d;
    step();
    we4   = 1'b0;
    data4 = ~d;
  endtask

  logic [9:0] pat;
  logic       lv [40];
  int         first_low, first_high, idle_rise;

  initial begin
    rst_n = 1'b0;
    we4 = 1'b0; we8 = 1'b0; data4 = 8'h00; data8 = 8'h00;
    n = 0; ovf_seen = 0; fs = 0; fbyte = 8'h00;
    model_reset();
    #12;
    chk("rst_txd4", txd4, 1'b1);
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_idle4", idle4, 1'b1);
    chk("rst_ovf4", ovf4, 1'b0);
    chk("rst_txd8", txd8, 1'b1);
    chk("rst_idle8", idle8, 1'b1);
    rst_n = 1'b1;

    // Single 0xA5 frame: explicit level table besides the model
    wr4(8'hA5);
    for (int i = 0; i < 44; i++) begin
      step();
      if (i < 40) lv[i] = txd4;
    end
    pat = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) chk("a5_level", lv[i], pat[i/4]);

    // Back-to-back frames
    wr4(8'h55);
    wr4(8'h0F);
    for (int i = 0; i < 85; i++) step();

    // Overflow: six writes into a 4-deep FIFO
    ovf_seen = 0;
    for (int i = 1; i <= 6; i++) wr4(8'(i));
    for (int i = 0; i < 210; i++) step();
    chk("overflow_pulses", ovf_seen, 1);

    // Write one edge before / exactly at the STOP period end
    wr4(8'($urandom));
    for (int i = 0; i < 39; i++) step();
    wr4(8'($urandom));
    step();
    chk("back_to_back_start", txd4, 1'b0);
    for (int i = 0; i < 39; i++) step();
    wr4(8'($urandom));
    chk("late_write_idle_gap", txd4, 1'b1);
    step();
    chk("late_write_start", txd4, 1'b0);
    for (int i = 0; i < 45; i++) step();

    // Reset during DATA bit 3 with two bytes queued
    wr4(8'hF0);
    wr4(8'($urandom));
    wr4(8'($urandom));
    for (int i = 0; i < 16; i++) step();
    chk("pre_reset_bit3", txd4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_txd", txd4, 1'b1);
    chk("async_rst_idle", idle4, 1'b1);
    chk("async_rst_busy", busy4, 1'b0);
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step();

    // Randomised traffic: a dense burst then a sparse trickle, then drain
    for (int i = 0; i < 400; i++) begin
      we4   = (i < 200) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 39) == 0);
      data4 = 8'($urandom);
      step();
    end
    we4 = 1'b0;
    for (int i = 0; i < 250; i++) step();

    // Default baud divisor: 0x00 frame timing
    data8 = 8'h00;
    we8   = 1'b1;
    step();
    we8   = 1'b0;
    data8 = 8'hFF;
    first_low = -1; first_high = -1; idle_rise = -1;
    for (int i = 1; i <= 8700; i++) begin
      step();
      if (first_low < 0 && txd8 == 1'b0) first_low = i;
      if (first_low >= 0 && first_high < 0 && txd8 == 1'b1) first_high = i;
      if (first_low >= 0 && idle_rise < 0 && idle8 == 1'b1) idle_rise = i;
    end
    chk("b868_fall", first_low, 1);
    chk("b868_rise", first_high, 1 + 9 * CB);
    chk("b868_idle", idle_rise, 1 + 10 * CB);
    chk("b868_line_end", txd8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter peripheral on the CPU's MMIO UART port (TX data register at 0x1000_0000, status at 0x1000_0004).
- Takes the 8-bit data and one-cycle write-enable pulse from the data-memory block, buffers bytes in a small FIFO, and serialises them on txd as 8N1 frames, LSB first.
- Drives the tx_busy status bit that software polls before each write.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200 baud); must be >= 2
FIFO_DEPTH, 4, bytes of TX buffering; power of two, >= 2

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  8  byte to transmit, sampled when tx_we=1
tx_we  input  1  one-cycle write strobe from the MMIO write path
tx_busy  output  1  FIFO full; software must not write while 1
tx_idle  output  1  FIFO empty and serialiser in IDLE
tx_overflow  output  1  one-cycle pulse: write dropped because FIFO was full
txd  output  1  serial line, idle high

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - txd=1, tx_busy=0, tx_idle=1, tx_overflow=0.
  - FIFO pointers and count = 0; FSM = IDLE; baud counter = 0; bit index = 0.
  - Reset mid-frame: txd returns to 1 immediately (asynchronously). Buffered bytes are discarded. Nothing resumes after release.
- FIFO:
  - Circular buffer, wr_ptr/rd_ptr modulo FIFO_DEPTH, count 0..FIFO_DEPTH.
  - tx_busy = (count == FIFO_DEPTH), decoded from the count register.
  - Write accepted at an edge when tx_we=1 and the pre-edge count < FIFO_DEPTH.
  - tx_we=1 with pre-edge count == FIFO_DEPTH: byte dropped, tx_overflow=1 for exactly one cycle. This holds even if a pop occurs on the same edge.
  - Simultaneous accepted write and pop: count unchanged; both pointers advance.
- FSM states:
  - IDLE: txd=1. If count>0: pop the head into an 8-bit shift register, clear the baud counter, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd = shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7's period, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At the end of the period:
    - if count>0, pop and go directly to START (no idle gap between frames);
    - otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Its terminal count advances the bit; the counter wraps to 0.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Write accepted at edge N with FSM in IDLE and FIFO empty: pop at edge N+1, txd falls after edge N+1.
- txd is a registered output (no glitches).
- tx_idle = (state==IDLE) && (count==0), registered or decoded from registers.
- tx_data is captured into the FIFO at the accepting edge. Later changes to tx_data do not affect a queued byte.

Test Plan:
- CLKS_PER_BIT=4, write 0xA5 once -> txd after pop edge is 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). Each level lasts 4 cycles (40 total). tx_idle=0 during the frame and returns to 1 at frame end.
- Write 0x55 then 0x0F on consecutive cycles -> two frames back-to-back, 80 cycles, second start bit begins the cycle after the first stop period. No idle cycles between frames.
- CLKS_PER_BIT=4, FIFO_DEPTH=4, six writes 0x01..0x06 on consecutive cycles:
  - 0x01 is popped immediately, so 0x01..0x05 are accepted;
  - tx_busy=1 before the 6th edge, 0x06 is dropped and tx_overflow pulses once;
  - tx_busy falls when 0x02 is popped at the end of frame 1 (cycle 40);
  - txd carries exactly 0x01..0x05.
- Write on the exact cycle the STOP period ends with FIFO otherwise empty -> no gap. The write and pop resolve per the rules above; the byte follows in the next frame, or after one IDLE cycle if it arrives one cycle late. The bench checks both alignments.
- Assert rst_n low during DATA bit 3 with two bytes queued -> txd=1 immediately, tx_idle=1, tx_busy=0. After release, txd stays 1 for 100 cycles with no frame.
- Default CLKS_PER_BIT=868, write 0x00 -> txd low for 9*868=7812 cycles, then high for 868 cycles. Bit-period edges are within ±0 cycles of the expected times.
